// File: rtl/control_pipeline_if.sv
// Control-unit boundary: Decode-stage instruction fields and Execute flags in,
// decoded and pipelined control signals out.
interface control_pipeline_if #(
  parameter int ALUC_W = 3
);
  logic [6:0]        op;
  logic [2:0]        func3;
  logic              func7_5;
  logic              stall_e;
  logic              flush_e;
  logic              zero_e;
  logic              lt_e;
  logic              ltu_e;
  logic [2:0]        imm_src_d;
  logic              illegal_d;
  logic              alu_src_e;
  logic [ALUC_W-1:0] alu_control_e;
  logic              jalr_e;
  logic              pc_src_e;
  logic              result_src_e0;
  logic              mem_write_m;
  logic              reg_write_m;
  logic [1:0]        result_src_w;
  logic              reg_write_w;
  logic              trap_w;

  // There is no valid/ready pair: every cycle carries one instruction slot,
  // and stall_e/flush_e from the hazard unit are the only flow control.
  modport master (
    output op, func3, func7_5, stall_e, flush_e, zero_e, lt_e, ltu_e,
    input  imm_src_d, illegal_d, alu_src_e, alu_control_e, jalr_e, pc_src_e,
           result_src_e0, mem_write_m, reg_write_m, result_src_w, reg_write_w, trap_w
  );

  modport slave (
    input  op, func3, func7_5, stall_e, flush_e, zero_e, lt_e, ltu_e,
    output imm_src_d, illegal_d, alu_src_e, alu_control_e, jalr_e, pc_src_e,
           result_src_e0, mem_write_m, reg_write_m, result_src_w, reg_write_w, trap_w
  );
endinterface

// File: rtl/control_pipeline.sv
// RV32I control unit: Decode-stage decoder plus the control bundle carried through
// the ID/EX, EX/MEM and MEM/WB registers, with branch resolution in Execute.
module control_pipeline #(
  parameter int ALUC_W      = 3,
  parameter int FULL_BRANCH = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  control_pipeline_if.slave  bus
);

  localparam logic [6:0] OP_LW   = 7'd3;
  localparam logic [6:0] OP_SW   = 7'd35;
  localparam logic [6:0] OP_R    = 7'd51;
  localparam logic [6:0] OP_I    = 7'd19;
  localparam logic [6:0] OP_BR   = 7'd99;
  localparam logic [6:0] OP_JAL  = 7'd111;
  localparam logic [6:0] OP_JALR = 7'd103;
  localparam logic [6:0] OP_LUI  = 7'd55;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef struct packed {
    logic              regWrite;
    logic              memWrite;
    logic [1:0]        resultSrc;
    logic              branch;
    logic              jump;
    logic              jalr;
    logic              aluSrc;
    logic [ALUC_W-1:0] aluControl;
    logic [2:0]        func3;
    logic              illegal;
  } exBundle_t;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic [1:0] resultSrc;
    logic       illegal;
  } memBundle_t;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       illegal;
  } wbBundle_t;

  exBundle_t  ctlD;
  exBundle_t  ctlE;
  memBundle_t ctlM;
  wbBundle_t  ctlW;
  logic [2:0] immSrcD;
  logic [3:0] aluRI;
  logic [3:0] aluOpD;
  logic       badEncoding;
  logic       takenE;

  // R/I-type ALU selection; bit 3 set marks the ops only a 4-bit ALU provides.
  always_comb begin
    aluRI = ALU_ADD;
    case (bus.func3)
      3'b000:  aluRI = ((bus.op == OP_R) && bus.func7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  aluRI = ALU_SLL;
      3'b010:  aluRI = ALU_SLT;
      3'b011:  aluRI = ALU_SLTU;
      3'b100:  aluRI = ALU_XOR;
      3'b101:  aluRI = bus.func7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  aluRI = ALU_OR;
      default: aluRI = ALU_AND;
    endcase
  end

  always_comb begin
    ctlD        = '0;
    immSrcD     = 3'b000;
    aluOpD      = ALU_ADD;
    badEncoding = 1'b0;
    case (bus.op)
      OP_LW: begin
        ctlD.regWrite  = 1'b1;
        ctlD.aluSrc    = 1'b1;
        ctlD.resultSrc = 2'b01;
      end
      OP_SW: begin
        immSrcD       = 3'b001;
        ctlD.aluSrc   = 1'b1;
        ctlD.memWrite = 1'b1;
      end
      OP_R: begin
        ctlD.regWrite = 1'b1;
        aluOpD        = aluRI;
      end
      OP_I: begin
        ctlD.regWrite = 1'b1;
        ctlD.aluSrc   = 1'b1;
        aluOpD        = aluRI;
      end
      OP_BR: begin
        immSrcD     = 3'b010;
        ctlD.branch = 1'b1;
        aluOpD      = ALU_SUB;
        badEncoding = (bus.func3[2:1] == 2'b01) ||
                      ((FULL_BRANCH == 0) && (bus.func3 != 3'b000));
      end
      OP_JAL: begin
        ctlD.regWrite  = 1'b1;
        immSrcD        = 3'b011;
        ctlD.resultSrc = 2'b10;
        ctlD.jump      = 1'b1;
      end
      OP_JALR: begin
        ctlD.regWrite  = 1'b1;
        ctlD.aluSrc    = 1'b1;
        ctlD.resultSrc = 2'b10;
        ctlD.jump      = 1'b1;
        ctlD.jalr      = 1'b1;
      end
      OP_LUI: begin
        ctlD.regWrite  = 1'b1;
        immSrcD        = 3'b100;
        ctlD.aluSrc    = 1'b1;
        ctlD.resultSrc = 2'b11;
      end
      default: badEncoding = 1'b1;
    endcase

    ctlD.illegal    = badEncoding || (aluOpD[3] && (ALUC_W < 4));
    ctlD.aluControl = aluOpD[ALUC_W-1:0];
    ctlD.func3      = bus.func3;
    // An illegal slot must not change architectural state; it only carries the trap.
    if (ctlD.illegal) begin
      ctlD.regWrite = 1'b0;
      ctlD.memWrite = 1'b0;
      ctlD.branch   = 1'b0;
      ctlD.jump     = 1'b0;
      ctlD.jalr     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctlE <= '0;
      ctlM <= '0;
      ctlW <= '0;
    end else begin
      if (bus.flush_e) begin
        ctlE <= '0;
      end else if (!bus.stall_e) begin
        ctlE <= ctlD;
      end

      // While Execute is held, its instruction must not also advance into Memory.
      if (bus.stall_e) begin
        ctlM <= '0;
      end else begin
        ctlM.regWrite  <= ctlE.regWrite;
        ctlM.memWrite  <= ctlE.memWrite;
        ctlM.resultSrc <= ctlE.resultSrc;
        ctlM.illegal   <= ctlE.illegal;
      end

      ctlW.regWrite  <= ctlM.regWrite;
      ctlW.resultSrc <= ctlM.resultSrc;
      ctlW.illegal   <= ctlM.illegal;
    end
  end

  always_comb begin
    takenE = 1'b0;
    case (ctlE.func3)
      3'b000:  takenE = bus.zero_e;
      3'b001:  takenE = !bus.zero_e;
      3'b100:  takenE = bus.lt_e;
      3'b101:  takenE = !bus.lt_e;
      3'b110:  takenE = bus.ltu_e;
      3'b111:  takenE = !bus.ltu_e;
      default: takenE = 1'b0;
    endcase
  end

  assign bus.imm_src_d     = immSrcD;
  assign bus.illegal_d     = ctlD.illegal;
  assign bus.alu_src_e     = ctlE.aluSrc;
  assign bus.alu_control_e = ctlE.aluControl;
  assign bus.jalr_e        = ctlE.jalr;
  assign bus.pc_src_e      = ctlE.jump | (ctlE.branch & takenE);
  assign bus.result_src_e0 = ctlE.resultSrc[0];
  assign bus.mem_write_m   = ctlM.memWrite;
  assign bus.reg_write_m   = ctlM.regWrite;
  assign bus.result_src_w  = ctlW.resultSrc;
  assign bus.reg_write_w   = ctlW.regWrite;
  assign bus.trap_w        = ctlW.illegal;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: a 4-bit/full-branch instance and a
// 3-bit/beq-only instance share stimulus; a monitor checks queued expectations.
module tb_control_pipeline;

  localparam int S_IMM    = 0;
  localparam int S_ILL    = 1;
  localparam int S_ALUSRC = 2;
  localparam int S_ALUC   = 3;
  localparam int S_JALR   = 4;
  localparam int S_PCSRC  = 5;
  localparam int S_RES0   = 6;
  localparam int S_MEMW_M = 7;
  localparam int S_REGW_M = 8;
  localparam int S_RESW   = 9;
  localparam int S_REGW_W = 10;
  localparam int S_TRAP   = 11;

  typedef struct {
    int         cyc;
    int         dsel;
    int         sid;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [6:0] tb_op = 7'd19;
  logic [2:0] tb_func3 = 3'd0;
  logic       tb_func7_5 = 1'b0;
  logic       tb_stall = 1'b0;
  logic       tb_flush = 1'b0;
  logic       tb_zero = 1'b0;
  logic       tb_lt = 1'b0;
  logic       tb_ltu = 1'b0;

  control_pipeline_if #(.ALUC_W(4)) io4 ();
  control_pipeline_if #(.ALUC_W(3)) io3 ();

  assign io4.op = tb_op;       assign io3.op = tb_op;
  assign io4.func3 = tb_func3; assign io3.func3 = tb_func3;
  assign io4.func7_5 = tb_func7_5; assign io3.func7_5 = tb_func7_5;
  assign io4.stall_e = tb_stall;   assign io3.stall_e = tb_stall;
  assign io4.flush_e = tb_flush;   assign io3.flush_e = tb_flush;
  assign io4.zero_e = tb_zero;     assign io3.zero_e = tb_zero;
  assign io4.lt_e = tb_lt;         assign io3.lt_e = tb_lt;
  assign io4.ltu_e = tb_ltu;       assign io3.ltu_e = tb_ltu;

  control_pipeline #(.ALUC_W(4), .FULL_BRANCH(1)) dut4 (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (io4)
  );

  control_pipeline #(.ALUC_W(3), .FULL_BRANCH(0)) dut3 (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (io3)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard ----------------
  function automatic logic [7:0] rd(int d, int s);
    logic [7:0] v;
    v = '0;
    case (s)
      S_IMM:    v = (d == 0) ? {5'b0, io4.imm_src_d}     : {5'b0, io3.imm_src_d};
      S_ILL:    v = (d == 0) ? {7'b0, io4.illegal_d}     : {7'b0, io3.illegal_d};
      S_ALUSRC: v = (d == 0) ? {7'b0, io4.alu_src_e}     : {7'b0, io3.alu_src_e};
      S_ALUC:   v = (d == 0) ? {4'b0, io4.alu_control_e} : {5'b0, io3.alu_control_e};
      S_JALR:   v = (d == 0) ? {7'b0, io4.jalr_e}        : {7'b0, io3.jalr_e};
      S_PCSRC:  v = (d == 0) ? {7'b0, io4.pc_src_e}      : {7'b0, io3.pc_src_e};
      S_RES0:   v = (d == 0) ? {7'b0, io4.result_src_e0} : {7'b0, io3.result_src_e0};
      S_MEMW_M: v = (d == 0) ? {7'b0, io4.mem_write_m}   : {7'b0, io3.mem_write_m};
      S_REGW_M: v = (d == 0) ? {7'b0, io4.reg_write_m}   : {7'b0, io3.reg_write_m};
      S_RESW:   v = (d == 0) ? {6'b0, io4.result_src_w}  : {6'b0, io3.result_src_w};
      S_REGW_W: v = (d == 0) ? {7'b0, io4.reg_write_w}   : {7'b0, io3.reg_write_w};
      default:  v = (d == 0) ? {7'b0, io4.trap_w}        : {7'b0, io3.trap_w};
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        logic [7:0] got;
        got = rd(exp_q[i].dsel, exp_q[i].sid);
        n_cmp++;
        if (exp_q[i].cyc < cyc || got !== exp_q[i].val) begin
          n_err++;
          $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", exp_q[i].name,
                   exp_q[i].dsel, cyc, got, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic chk(int dsel, int sid, logic [7:0] e, string nm);
    logic [7:0] got;
    got = rd(dsel, sid);
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, dsel, cyc, got, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  // dsel 0 = 4-bit/full-branch, 1 = 3-bit/beq-only, 2 = both
  task automatic put(int dsel, int off, int sid, logic [7:0] v, string nm);
    exp_t e;
    e.cyc = cyc + off; e.sid = sid; e.val = v; e.name = nm;
    if (dsel != 1) begin e.dsel = 0; exp_q.push_back(e); end
    if (dsel != 0) begin e.dsel = 1; exp_q.push_back(e); end
  endtask

  task automatic instr(logic [6:0] o, logic [2:0] f3, logic f75);
    tb_op = o; tb_func3 = f3; tb_func7_5 = f75;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tb_stall = 1'b0; tb_flush = 1'b0;
    tb_zero = 1'b0; tb_lt = 1'b0; tb_ltu = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step();
    put(2, 0, S_REGW_W, 8'd0, "rst_regw_w");
    put(2, 0, S_TRAP,   8'd0, "rst_trap");
    put(2, 0, S_PCSRC,  8'd0, "rst_pcsrc");
    put(2, 0, S_REGW_M, 8'd0, "rst_regw_m");
    step();
    rst_n = 1'b1;
    step();

    // R/I-type ALU decode
    instr(7'd51, 3'd0, 1'b1);
    put(2, 1, S_ALUC, 8'd1, "r_sub"); put(2, 1, S_ALUSRC, 8'd0, "r_alusrc");
    put(2, 2, S_REGW_M, 8'd1, "r_regw_m"); put(2, 3, S_REGW_W, 8'd1, "r_regw_w");
    put(2, 3, S_RESW, 8'd0, "r_resw");
    step();
    instr(7'd51, 3'd5, 1'b1);
    put(0, 1, S_ALUC, 8'd8, "r_sra4"); put(0, 0, S_ILL, 8'd0, "r_sra4_legal");
    put(0, 3, S_TRAP, 8'd0, "r_sra4_notrap");
    put(1, 0, S_ILL, 8'd1, "r_sra3_ill"); put(1, 3, S_TRAP, 8'd1, "r_sra3_trap");
    put(1, 3, S_REGW_W, 8'd0, "r_sra3_noregw");
    step();
    instr(7'd19, 3'd3, 1'b0);
    put(0, 1, S_ALUC, 8'd9, "i_sltu4"); put(0, 1, S_ALUSRC, 8'd1, "i_alusrc");
    put(1, 0, S_ILL, 8'd1, "i_sltu3_ill");
    step();
    instr(7'd19, 3'd0, 1'b1);
    put(2, 1, S_ALUC, 8'd0, "i_add_f75");
    step();
    instr(7'd51, 3'd7, 1'b0);
    put(2, 1, S_ALUC, 8'd2, "r_and");
    step();
    instr(7'd19, 3'd4, 1'b0);
    put(2, 1, S_ALUC, 8'd4, "i_xor");
    step();

    // Branches: flags for the instruction in Execute are set the following cycle
    instr(7'd99, 3'd1, 1'b0);
    put(0, 0, S_IMM, 8'd2, "br_imm"); put(0, 1, S_PCSRC, 8'd1, "bne_taken");
    put(1, 0, S_ILL, 8'd1, "bne_beqonly_ill"); put(1, 1, S_PCSRC, 8'd0, "bne_beqonly_pc");
    step();
    instr(7'd99, 3'd6, 1'b0);
    put(0, 1, S_PCSRC, 8'd0, "bltu_nt");
    step();
    tb_zero = 1'b1;
    instr(7'd99, 3'd0, 1'b0);
    put(2, 1, S_PCSRC, 8'd1, "beq_taken");
    step();
    tb_zero = 1'b1;
    instr(7'd99, 3'd2, 1'b0);
    put(0, 0, S_ILL, 8'd1, "br010_ill"); put(2, 1, S_PCSRC, 8'd0, "br010_pc");
    step();
    tb_zero = 1'b1;
    instr(7'd99, 3'd5, 1'b0);
    put(0, 1, S_PCSRC, 8'd1, "bge_taken");
    step();
    instr(7'd99, 3'd4, 1'b0);
    put(0, 1, S_PCSRC, 8'd0, "blt_nt");
    step();
    instr(7'd19, 3'd0, 1'b0);
    step();

    // Jumps, lui, store, unknown opcode
    instr(7'd111, 3'd0, 1'b0);
    put(2, 0, S_IMM, 8'd3, "jal_imm"); put(2, 1, S_PCSRC, 8'd1, "jal_pc");
    put(2, 3, S_RESW, 8'd2, "jal_resw"); put(2, 3, S_REGW_W, 8'd1, "jal_regw");
    step();
    instr(7'd103, 3'd0, 1'b0);
    put(2, 1, S_JALR, 8'd1, "jalr_e"); put(2, 1, S_PCSRC, 8'd1, "jalr_pc");
    put(2, 1, S_ALUSRC, 8'd1, "jalr_alusrc"); put(2, 3, S_RESW, 8'd2, "jalr_resw");
    step();
    instr(7'd55, 3'd0, 1'b0);
    put(2, 0, S_IMM, 8'd4, "lui_imm"); put(2, 1, S_PCSRC, 8'd0, "lui_pc");
    put(2, 1, S_JALR, 8'd0, "lui_jalr"); put(2, 3, S_RESW, 8'd3, "lui_resw");
    put(2, 3, S_REGW_W, 8'd1, "lui_regw");
    #1;
    chk(0, S_IMM, 8'd4, "lui_imm_now4"); chk(1, S_IMM, 8'd4, "lui_imm_now3");
    step();
    instr(7'd35, 3'd2, 1'b0);
    put(2, 0, S_IMM, 8'd1, "sw_imm"); put(2, 2, S_MEMW_M, 8'd1, "sw_memw");
    put(2, 2, S_REGW_M, 8'd0, "sw_regw");
    step();
    instr(7'd0, 3'd0, 1'b0);
    put(2, 0, S_ILL, 8'd1, "op0_ill"); put(2, 1, S_PCSRC, 8'd0, "op0_pc");
    put(2, 2, S_REGW_M, 8'd0, "op0_regw_m"); put(2, 2, S_MEMW_M, 8'd0, "op0_memw_m");
    put(2, 3, S_REGW_W, 8'd0, "op0_regw_w"); put(2, 3, S_TRAP, 8'd1, "op0_trap");
    #1;
    chk(0, S_ILL, 8'd1, "op0_ill_now4"); chk(1, S_ILL, 8'd1, "op0_ill_now3");
    step();
    instr(7'd19, 3'd0, 1'b0);
    step();

    // Stall and flush
    instr(7'd3, 3'd2, 1'b0);
    put(2, 1, S_RES0, 8'd1, "lw_res0"); put(2, 1, S_ALUSRC, 8'd1, "lw_alusrc");
    step();
    instr(7'd35, 3'd2, 1'b0); tb_stall = 1'b1;
    put(2, 1, S_RES0, 8'd1, "stall_hold"); put(2, 1, S_REGW_M, 8'd0, "stall_bub_regw");
    put(2, 1, S_MEMW_M, 8'd0, "stall_bub_memw");
    step();
    instr(7'd35, 3'd2, 1'b0);
    put(2, 1, S_RES0, 8'd0, "sw_after_stall"); put(2, 1, S_REGW_M, 8'd1, "lw_after_stall");
    put(2, 2, S_MEMW_M, 8'd1, "sw_mem_after_stall");
    step();
    instr(7'd3, 3'd2, 1'b0);
    step();
    instr(7'd3, 3'd2, 1'b0); tb_stall = 1'b1; tb_flush = 1'b1;
    put(2, 1, S_RES0, 8'd0, "flush_wins_res0"); put(2, 1, S_ALUSRC, 8'd0, "flush_wins_alusrc");
    put(2, 1, S_REGW_M, 8'd0, "flush_stall_regw_m");
    step();
    instr(7'd19, 3'd0, 1'b0);
    step();
    instr(7'd111, 3'd0, 1'b0);
    step();
    instr(7'd19, 3'd0, 1'b0); tb_flush = 1'b1;
    put(2, 0, S_PCSRC, 8'd1, "jal_before_flush"); put(2, 1, S_PCSRC, 8'd0, "flush_jal_pc");
    put(2, 1, S_REGW_M, 8'd1, "flush_jal_regw_m");
    step();
    instr(7'd19, 3'd0, 1'b0);
    step();

    // Reset mid-stream
    instr(7'd19, 3'd0, 1'b0);
    step();
    instr(7'd3, 3'd2, 1'b0);
    put(2, 1, S_RES0, 8'd1, "pre_rst_lw");
    step();
    instr(7'd111, 3'd0, 1'b0);
    step();
    rst_n = 1'b0;
    instr(7'd35, 3'd2, 1'b0);
    put(2, 0, S_PCSRC, 8'd0, "midrst_pc"); put(2, 0, S_REGW_M, 8'd0, "midrst_regw_m");
    put(2, 0, S_REGW_W, 8'd0, "midrst_regw_w"); put(2, 0, S_RES0, 8'd0, "midrst_res0");
    #1;
    chk(0, S_PCSRC, 8'd0, "midrst_pc_now4"); chk(1, S_PCSRC, 8'd0, "midrst_pc_now3");
    chk(0, S_REGW_W, 8'd0, "midrst_regw_w_now4"); chk(0, S_TRAP, 8'd0, "midrst_trap_now4");
    step();
    instr(7'd3, 3'd2, 1'b0);
    put(2, 0, S_REGW_M, 8'd0, "inrst_regw_m"); put(2, 0, S_PCSRC, 8'd0, "inrst_pc");
    step();
    rst_n = 1'b1;
    instr(7'd3, 3'd2, 1'b0);
    put(2, 2, S_REGW_M, 8'd1, "postrst_regw_m"); put(2, 3, S_REGW_W, 8'd1, "postrst_regw_w");
    put(2, 3, S_RESW, 8'd1, "postrst_resw");
    step();
    instr(7'd19, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) step();

    // ---------------- final report ----------------
    foreach (exp_q[i]) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s dut%0d: never checked, expected %0h at cyc %0d", exp_q[i].name,
               exp_q[i].dsel, exp_q[i].val, exp_q[i].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    if (n_err == 0 && n_cmp > 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
